// File: rtl/demux_12_pkg.sv
// demux_12_pkg: shared widths, lane type and counter helpers for the demux_12 slice.
package demux_12_pkg;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_DEPTH = 2;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_SAT = 8'd255;
    typedef logic lane_t;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/demux_12_if.sv
// demux_12_if: upstream stream plus both lane outputs; count ports exist only with DEMUX_12_STATS_EN.
interface demux_12_if #(parameter int DATA_W = demux_12_pkg::DEF_DATA_W);
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              ready_in;
    logic [DATA_W-1:0] data_0;
    logic              valid_0;
    logic              ready_0;
    logic [DATA_W-1:0] data_1;
    logic              valid_1;
    logic              ready_1;
`ifdef DEMUX_12_STATS_EN
    logic [demux_12_pkg::CNT_W-1:0] count_0;
    logic [demux_12_pkg::CNT_W-1:0] count_1;
    modport master (output valid_in, data_in, ready_0, ready_1,
                    input ready_in, data_0, valid_0, data_1, valid_1, count_0, count_1);
    modport slave (input valid_in, data_in, ready_0, ready_1,
                   output ready_in, data_0, valid_0, data_1, valid_1, count_0, count_1);
`else
    modport master (output valid_in, data_in, ready_0, ready_1,
                    input ready_in, data_0, valid_0, data_1, valid_1);
    modport slave (input valid_in, data_in, ready_0, ready_1,
                   output ready_in, data_0, valid_0, data_1, valid_1);
`endif
endinterface

// File: rtl/demux_12_lane_fifo.sv
// lane_fifo: small power-of-two FIFO whose head is registered and holds the last popped word when empty.
module lane_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int PW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PW:0] cnt_q, cnt_d, left;
    logic [DATA_W-1:0] head_q, head_d;
    logic do_push, do_pop;
    assign full = cnt_q == (PW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign head = head_q;
    // The next head comes from storage if anything survives the pop, else from the incoming word.
    always_comb begin
        do_push = push && !full;
        do_pop = pop && !empty;
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d = do_push ? wr_q + 1'b1 : wr_q;
        rd_d = do_pop ? rd_q + 1'b1 : rd_q;
        left = cnt_q - {{PW{1'b0}}, do_pop};
        cnt_d = left + {{PW{1'b0}}, do_push};
        head_d = (left != '0) ? mem_q[rd_d] : (do_push ? din : head_q);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
            head_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            cnt_q <= cnt_d;
            head_q <= head_d;
        end
    end
endmodule

// File: rtl/demux_12.sv
// demux_12: round-robin 1:2 demux feeding two lane FIFOs; DEMUX_12_STATS_EN adds saturating per-lane counters.
module demux_12
    import demux_12_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic     clk,
    input logic     reset,
    demux_12_if.slave bus
);
    lane_t sel_q, sel_d;
    logic full_0, full_1, empty_0, empty_1, accept, push_0, push_1;
    // A stalled target lane blocks the stream; no pass-through from ready_0/ready_1.
    always_comb begin
        bus.ready_in = sel_q ? !full_1 : !full_0;
        accept = bus.valid_in && bus.ready_in;
        push_0 = accept && (sel_q == 1'b0);
        push_1 = accept && (sel_q == 1'b1);
        sel_d = accept ? ~sel_q : sel_q;
        bus.valid_0 = !empty_0;
        bus.valid_1 = !empty_1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sel_q <= 1'b0;
        else sel_q <= sel_d;
    end
    lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane_0 (
        .clk(clk), .reset(reset), .push(push_0), .pop(bus.ready_0), .din(bus.data_in),
        .full(full_0), .empty(empty_0), .head(bus.data_0)
    );
    lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane_1 (
        .clk(clk), .reset(reset), .push(push_1), .pop(bus.ready_1), .din(bus.data_in),
        .full(full_1), .empty(empty_1), .head(bus.data_1)
    );
`ifdef DEMUX_12_STATS_EN
    logic [CNT_W-1:0] count_0_q, count_0_d, count_1_q, count_1_d;
    always_comb begin
        count_0_d = push_0 ? sat_inc(count_0_q) : count_0_q;
        count_1_d = push_1 ? sat_inc(count_1_q) : count_1_q;
        bus.count_0 = count_0_q;
        bus.count_1 = count_1_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_0_q <= '0;
            count_1_q <= '0;
        end else begin
            count_0_q <= count_0_d;
            count_1_q <= count_1_d;
        end
    end
`endif
endmodule

// File: tb/tb_demux_12.sv
// tb_demux_12: table-driven directed checks of demux_12 plus reset and counter sequences.
module tb_demux_12;
    typedef struct {
        logic       vin;
        logic [3:0] din;
        logic       r0;
        logic       r1;
        logic       rdy;
        logic       v0;
        logic [3:0] d0;
        logic       v1;
        logic [3:0] d1;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int passed = 0;
    vec_t vecs [17];

    always #5 clk = ~clk;

    demux_12_if bus ();
    demux_12 dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic vec_t mk(input logic vin, input logic [3:0] din, input logic r0, input logic r1,
                                input logic rdy, input logic v0, input logic [3:0] d0,
                                input logic v1, input logic [3:0] d1);
        vec_t v;
        v.vin = vin; v.din = din; v.r0 = r0; v.r1 = r1;
        v.rdy = rdy; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic chk_outs(input string tag, input logic rdy, input logic v0, input logic [3:0] d0,
                            input logic v1, input logic [3:0] d1);
        chk({tag, " ready_in"}, 8'(bus.ready_in), 8'(rdy));
        chk({tag, " valid_0"}, 8'(bus.valid_0), 8'(v0));
        chk({tag, " data_0"}, 8'(bus.data_0), 8'(d0));
        chk({tag, " valid_1"}, 8'(bus.valid_1), 8'(v1));
        chk({tag, " data_1"}, 8'(bus.data_1), 8'(d1));
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in = 4'h0;
        bus.ready_0 = 1'b0;
        bus.ready_1 = 1'b0;
        // Expected outputs are the state seen before the edge on which the row's inputs act.
        vecs[0]  = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        vecs[1]  = mk(1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        vecs[2]  = mk(1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0);
        vecs[3]  = mk(1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 1'b1, 4'h2);
        vecs[4]  = mk(1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 4'h2);
        vecs[5]  = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 4'h4);
        vecs[6]  = mk(1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 4'h4);
        vecs[7]  = mk(1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 4'h4);
        vecs[8]  = mk(1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b1, 4'h6);
        vecs[9]  = mk(1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 4'h6);
        vecs[10] = mk(1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 1'b1, 4'h8);
        vecs[11] = mk(1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 4'h8);
        vecs[12] = mk(1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 4'h8);
        vecs[13] = mk(1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 4'h8);
        vecs[14] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h7, 1'b1, 4'hA);
        vecs[15] = mk(1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 1'b1, 4'h9, 1'b1, 4'hA);
        vecs[16] = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hB, 1'b1, 4'hA);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
`ifdef DEMUX_12_STATS_EN
        chk("reset count_0", bus.count_0, 8'd0);
        chk("reset count_1", bus.count_1, 8'd0);
`endif
        for (int i = 0; i < 17; i++) begin
            bus.valid_in = vecs[i].vin;
            bus.data_in = vecs[i].din;
            bus.ready_0 = vecs[i].r0;
            bus.ready_1 = vecs[i].r1;
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1);
            @(posedge clk);
            #1;
        end

        // Both lanes hold a word here; reset must clear them without waiting for an edge.
        #2 reset = 1'b1;
        #1;
        chk_outs("midreset", 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
`ifdef DEMUX_12_STATS_EN
        chk("midreset count_0", bus.count_0, 8'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in = 4'hC;
        bus.ready_0 = 1'b0;
        bus.ready_1 = 1'b0;
        #1;
        chk("post-reset ready_in", 8'(bus.ready_in), 8'd1);
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        chk_outs("after C", 1'b1, 1'b1, 4'hC, 1'b0, 4'h0);

`ifdef DEMUX_12_STATS_EN
        chk("count_0 after C", bus.count_0, 8'd1);
        chk("count_1 after C", bus.count_1, 8'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.ready_0 = 1'b1;
        bus.ready_1 = 1'b1;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.data_in = 4'(i);
            @(posedge clk);
            #1;
        end
        bus.valid_in = 1'b0;
        #1;
        chk("count_0 300", bus.count_0, 8'd150);
        chk("count_1 300", bus.count_1, 8'd150);
        bus.valid_in = 1'b1;
        for (int i = 0; i < 220; i++) begin
            bus.data_in = 4'(i);
            @(posedge clk);
            #1;
        end
        bus.valid_in = 1'b0;
        #1;
        chk("count_0 520", bus.count_0, 8'd255);
        chk("count_1 520", bus.count_1, 8'd255);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/demux_12.md
# demux_12

Round-robin 1:2 demultiplexer that sits directly upstream of the 2:1 mux stage and produces its two data lanes. It accepts a single 4-bit word stream with a valid/ready handshake and distributes consecutive words alternately to lane 0 and lane 1. Each lane has its own small FIFO, so the two mux inputs can be drained independently.

## Interface
- DATA_W, 4: word width on input and both lanes.
- DEPTH, 2: entries per lane FIFO; power of two, ≥2.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  upstream word present on data_in.
- data_in  input  DATA_W  upstream word.
- ready_in  output  1  demux can accept a word this cycle.
- data_0  output  DATA_W  head of lane 0 FIFO; feeds mux data_0.
- valid_0  output  1  lane 0 FIFO non-empty.
- ready_0  input  1  lane 0 consumer takes head this cycle.
- data_1, valid_1, ready_1: same as lane 0, for lane 1.
- count_0, count_1  output  8  per-lane accepted-word counters; present only with DEMUX_12_STATS_EN.

## Operation
- State: lane pointer sel (1 bit), two lane FIFOs (DEPTH entries, read/write pointers plus occupancy, width clog2(DEPTH)+1).
- Reset: sel=0, both FIFOs empty. Outputs: ready_in=1, valid_0=valid_1=0, data_0=data_1=0, count_0=count_1=0.
- ready_in = not full(lane sel). It never depends on ready_0/ready_1 in the same cycle: no pass-through when full.
- Accept: valid_in && ready_in at a posedge. data_in is written to lane sel, and sel toggles.
- No accept means sel holds. Words always alternate 0,1,0,1… regardless of stalls. A stalled lane blocks the stream even when the other lane has space.
- Pop: valid_x && ready_x at a posedge removes the head of lane x. ready_x while empty is ignored.
- Simultaneous push and pop on the same lane: both happen, occupancy is unchanged. This is legal when the lane is not full, including a one-entry lane.
- Empty lane: data_x shows the last popped value, or 0 after reset. Consumers must qualify with valid_x.
- Pointers wrap modulo DEPTH. Occupancy never exceeds DEPTH or goes below 0.
- Reset asserted mid-operation: all FIFO contents are discarded immediately and sel returns to 0.

## Timing
- Latency 1: a word accepted at edge N is visible on data_x with valid_x=1 after edge N.
- Throughput: 1 word/cycle when both consumers hold ready high.
- ready_in updates after each edge from registered occupancy and sel. It is combinational from registers only, with no input-to-output path.
- valid_x and data_x are driven purely from registers.
- Reset acts asynchronously on assertion. The first accept is possible at the first posedge after deassertion.

## Configuration
- DEMUX_12_STATS_EN defined: count_0 and count_1 exist. Each increments by 1 on every accept into its lane and saturates at 255. They clear on reset.
- Not defined: the count ports and counters are absent. All other behaviour is identical.

## Structure
- Package demux_12_pkg: DATA_W and DEPTH defaults, lane index type (1 bit), counter width constant (8), counter saturation value (255).
- Sub-module lane_fifo: parameterised DATA_W/DEPTH FIFO with push, pop, full, empty, and head data. It is instantiated twice.
- The top level contains sel, the ready_in logic, push steering and the optional counters.

## Test plan
- Reset with valid_in=0 → ready_in=1, valid_0=valid_1=0, data_0=data_1=0.
- Stream 0x1,0x2,0x3,0x4 on consecutive cycles with ready_0=ready_1=1 → lane 0 sees 0x1 then 0x3, lane 1 sees 0x2 then 0x4, each one cycle after accept.
- Hold ready_0=0 and offer 0x5..0xA continuously → lane 0 fills with 0x5,0x7 and lane 1 receives 0x6,0x8. ready_in drops when sel=0 and lane 0 is full. Raising ready_0 for one cycle then admits 0x9.
- Lane 0 holds one entry; assert push and pop on lane 0 in the same cycle → head advances, valid_0 stays 1, occupancy stays 1.
- Assert reset for one cycle mid-stream with both lanes non-empty → valid_0=valid_1=0 immediately. The next accepted word 0xC goes to lane 0.
- With DEMUX_12_STATS_EN, push 300 words with both ready high → count_0=count_1=150. Push 520 words → both saturate at 255.
